// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC write port, issues single-outstanding imem requests and
// buffers fetched instructions in a slot+skid pair toward IF/ID.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0010
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_next,
    output logic        o_pc_wr_en,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    input  logic        i_if_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_trap
);

    typedef enum logic [1:0] {StRst, StReq, StWait, StDrop} state_e;

    state_e      state_q, state_d;
    logic        slot_valid_q, skid_valid_q;
    logic [31:0] slot_instr_q, slot_pc_q;
    logic [31:0] skid_instr_q, skid_pc_q;
    logic [31:0] req_pc_q;

    logic flush, grant, consume, accept;

    assign flush   = (state_q != StRst) && (i_trap || i_redirect);
    assign consume = slot_valid_q && !i_if_stall;
    assign accept  = (state_q == StWait) && i_imem_rvalid && !flush;

    // A full skid means the slot is stalled; hold off fetching until it drains.
    assign o_imem_req  = (state_q == StReq) && !skid_valid_q;
    assign o_imem_addr = i_pc;
    assign grant       = o_imem_req && i_imem_gnt;

    assign o_if_valid = slot_valid_q;
    assign o_if_instr = slot_instr_q;
    assign o_if_pc    = slot_pc_q;

    always_comb begin
        state_d    = state_q;
        o_pc_wr_en = 1'b0;
        o_pc_next  = i_pc;
        case (state_q)
            StRst: begin
                o_pc_wr_en = 1'b1;
                o_pc_next  = RESET_VEC;
                state_d    = StReq;
            end
            StReq: begin
                if (grant) begin
                    o_pc_wr_en = 1'b1;
                    o_pc_next  = i_pc + 32'd4;
                    state_d    = flush ? StDrop : StWait;
                end
            end
            StWait: begin
                if (i_imem_rvalid) begin
                    state_d = StReq;
                end else if (flush) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                // The stale response is swallowed here; only then is the bus free again.
                if (i_imem_rvalid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StRst;
        endcase
        if (flush) begin
            o_pc_wr_en = 1'b1;
            o_pc_next  = i_trap ? TRAP_VEC : i_redirect_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_valid_q <= 1'b0;
            slot_instr_q <= 32'd0;
            slot_pc_q    <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc_q    <= 32'd0;
            req_pc_q     <= 32'd0;
        end else begin
            if (grant) begin
                req_pc_q <= i_pc;
            end
            if (flush) begin
                slot_valid_q <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (consume && skid_valid_q) begin
                slot_instr_q <= skid_instr_q;
                slot_pc_q    <= skid_pc_q;
                skid_valid_q <= accept;
                if (accept) begin
                    skid_instr_q <= i_imem_rdata;
                    skid_pc_q    <= req_pc_q;
                end
            end else if (accept) begin
                if (!slot_valid_q || consume) begin
                    slot_valid_q <= 1'b1;
                    slot_instr_q <= i_imem_rdata;
                    slot_pc_q    <= req_pc_q;
                end else begin
                    skid_valid_q <= 1'b1;
                    skid_instr_q <= i_imem_rdata;
                    skid_pc_q    <= req_pc_q;
                end
            end else if (consume) begin
                slot_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a PC register and a fixed-latency imem responder.
module tb_pc_fetch_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic [31:0] o_pc_next;
    logic        o_pc_wr_en;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        i_if_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_trap;

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder state; instruction word is the address xor a fixed tag.
    logic        pend;
    int          cnt;
    int          mem_lat;
    logic [31:0] raddr;

    pc_fetch_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_pc          (i_pc),
        .o_pc_next     (o_pc_next),
        .o_pc_wr_en    (o_pc_wr_en),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_valid    (o_if_valid),
        .o_if_instr    (o_if_instr),
        .o_if_pc       (o_if_pc),
        .i_if_stall    (i_if_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_trap        (i_trap)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_pc_wr_en === 1'b1) begin
            i_pc <= o_pc_next;
        end
    end

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            pend <= 1'b0;
            cnt  <= 0;
        end else if (o_imem_req && i_imem_gnt) begin
            pend  <= 1'b1;
            cnt   <= 1;
            raddr <= o_imem_addr;
        end else if (i_imem_rvalid) begin
            pend <= 1'b0;
        end else if (pend) begin
            cnt <= cnt + 1;
        end
    end

    assign i_imem_rvalid = pend && (cnt == mem_lat);
    assign i_imem_rdata  = raddr ^ 32'hDEAD_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_rst_n       = 1'b0;
        i_imem_gnt    = 1'b1;
        i_if_stall    = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        i_trap        = 1'b0;
        mem_lat       = 1;
        raddr         = 32'd0;

        // Reset state and sequential fetch
        step();
        step();
        check("rst_if_valid", {31'd0, o_if_valid}, 32'd0);
        check("rst_req", {31'd0, o_imem_req}, 32'd0);
        check("rst_wr_en", {31'd0, o_pc_wr_en}, 32'd1);
        check("rst_pc_next", o_pc_next, 32'h0);
        check("rst_instr", o_if_instr, 32'h0);
        check("rst_if_pc", o_if_pc, 32'h0);
        i_rst_n = 1'b1;
        step();
        check("seq_req0", {31'd0, o_imem_req}, 32'd1);
        check("seq_addr0", o_imem_addr, 32'h0);
        check("seq_pc_next0", o_pc_next, 32'h4);
        step();
        check("seq_wait_req", {31'd0, o_imem_req}, 32'd0);
        check("seq_wait_valid", {31'd0, o_if_valid}, 32'd0);
        check("seq_pc4", i_pc, 32'h4);
        step();
        check("seq_valid0", {31'd0, o_if_valid}, 32'd1);
        check("seq_if_pc0", o_if_pc, 32'h0);
        check("seq_instr0", o_if_instr, 32'hDEAD_0000);
        check("seq_addr4", o_imem_addr, 32'h4);
        step();
        check("seq_gap_valid", {31'd0, o_if_valid}, 32'd0);
        step();
        check("seq_valid4", {31'd0, o_if_valid}, 32'd1);
        check("seq_if_pc4", o_if_pc, 32'h4);
        check("seq_instr4", o_if_instr, 32'hDEAD_0004);
        check("seq_pc8", i_pc, 32'h8);

        // Stall fills the skid and blocks further requests
        do_reset();
        step();
        step();
        step();
        check("stl_first_pc", o_if_pc, 32'h0);
        i_if_stall = 1'b1;
        repeat (6) step();
        check("stl_valid", {31'd0, o_if_valid}, 32'd1);
        check("stl_if_pc", o_if_pc, 32'h0);
        check("stl_req", {31'd0, o_imem_req}, 32'd0);
        check("stl_pc", i_pc, 32'h8);
        i_if_stall = 1'b0;
        step();
        check("stl_skid_pc", o_if_pc, 32'h4);
        check("stl_skid_instr", o_if_instr, 32'hDEAD_0004);
        check("stl_resume_req", {31'd0, o_imem_req}, 32'd1);
        check("stl_resume_addr", o_imem_addr, 32'h8);
        step();
        check("stl_gap_valid", {31'd0, o_if_valid}, 32'd0);
        step();
        check("stl_if_pc8", o_if_pc, 32'h8);
        check("stl_instr8", o_if_instr, 32'hDEAD_0008);

        // Redirect while waiting on a 2-cycle response
        mem_lat = 2;
        do_reset();
        step();
        check("rdr_addr0", o_imem_addr, 32'h0);
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        #1;
        check("rdr_wr_en", {31'd0, o_pc_wr_en}, 32'd1);
        check("rdr_pc_next", o_pc_next, 32'h100);
        step();
        i_redirect = 1'b0;
        #1;
        check("rdr_drop_req", {31'd0, o_imem_req}, 32'd0);
        check("rdr_drop_valid", {31'd0, o_if_valid}, 32'd0);
        step();
        check("rdr_req", {31'd0, o_imem_req}, 32'd1);
        check("rdr_addr", o_imem_addr, 32'h100);
        check("rdr_valid_a", {31'd0, o_if_valid}, 32'd0);
        step();
        check("rdr_valid_b", {31'd0, o_if_valid}, 32'd0);
        step();
        check("rdr_valid_c", {31'd0, o_if_valid}, 32'd0);
        step();
        check("rdr_valid", {31'd0, o_if_valid}, 32'd1);
        check("rdr_if_pc", o_if_pc, 32'h100);
        check("rdr_instr", o_if_instr, 32'hDEAD_0100);

        // Trap and redirect together with a grant
        mem_lat = 1;
        do_reset();
        step();
        i_trap        = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        #1;
        check("trp_req", {31'd0, o_imem_req}, 32'd1);
        check("trp_pc_next", o_pc_next, 32'h10);
        check("trp_wr_en", {31'd0, o_pc_wr_en}, 32'd1);
        step();
        i_trap     = 1'b0;
        i_redirect = 1'b0;
        #1;
        check("trp_drop_req", {31'd0, o_imem_req}, 32'd0);
        check("trp_valid_a", {31'd0, o_if_valid}, 32'd0);
        check("trp_pc", i_pc, 32'h10);
        step();
        check("trp_addr", o_imem_addr, 32'h10);
        check("trp_valid_b", {31'd0, o_if_valid}, 32'd0);
        step();
        check("trp_valid_c", {31'd0, o_if_valid}, 32'd0);
        step();
        check("trp_valid", {31'd0, o_if_valid}, 32'd1);
        check("trp_if_pc", o_if_pc, 32'h10);
        check("trp_instr", o_if_instr, 32'hDEAD_0010);

        // PC wrap at the top of the address space
        i_imem_gnt = 1'b0;
        do_reset();
        step();
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        #1;
        check("wrp_redir_next", o_pc_next, 32'hFFFF_FFFC);
        step();
        i_redirect = 1'b0;
        i_imem_gnt = 1'b1;
        #1;
        check("wrp_addr", o_imem_addr, 32'hFFFF_FFFC);
        check("wrp_pc_next", o_pc_next, 32'h0);
        check("wrp_wr_en", {31'd0, o_pc_wr_en}, 32'd1);
        step();
        check("wrp_pc", i_pc, 32'h0);
        step();
        check("wrp_if_pc", o_if_pc, 32'hFFFF_FFFC);
        check("wrp_instr", o_if_instr, 32'h2152_FFFC);

        // Reset pulse while a request is outstanding
        mem_lat = 2;
        step();
        check("mrst_wait_req", {31'd0, o_imem_req}, 32'd0);
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        #1;
        check("mrst_valid", {31'd0, o_if_valid}, 32'd0);
        check("mrst_pc_next", o_pc_next, 32'h0);
        check("mrst_wr_en", {31'd0, o_pc_wr_en}, 32'd1);
        check("mrst_req", {31'd0, o_imem_req}, 32'd0);
        step();
        check("mrst_req1", {31'd0, o_imem_req}, 32'd1);
        check("mrst_addr", o_imem_addr, 32'h0);
        step();
        step();
        step();
        check("mrst_if_valid", {31'd0, o_if_valid}, 32'd1);
        check("mrst_if_pc", o_if_pc, 32'h0);
        check("mrst_instr", o_if_instr, 32'hDEAD_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
